// File: rtl/ccr_pkg.sv
// rtl/ccr_pkg.sv - shared state type and default counter values for the clock/reset controller
package ccr_pkg;

  typedef enum logic [1:0] {
    RESET_ST,
    WAIT_LOCK_ST,
    RUN_ST
  } ccr_state_t;

  localparam int unsigned SYSRST_DEBOUNCE_COUNTER_VALUE_DEF = 1000000;
  localparam int unsigned PLL_LOCK_COUNTER_VALUE_DEF        = 1000;

endpackage

// File: rtl/ccr_debounce.sv
// rtl/ccr_debounce.sv - two-flop synchroniser and debouncer for the raw reset button
module ccr_debounce
  import ccr_pkg::*;
#(
  parameter int unsigned SYSRST_DEBOUNCE_COUNTER_VALUE_p = SYSRST_DEBOUNCE_COUNTER_VALUE_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_rst_n,
  output logic o_btn_db
);

  localparam int unsigned DW = $clog2(SYSRST_DEBOUNCE_COUNTER_VALUE_p + 1);
  localparam logic [DW-1:0] D_LAST = DW'(SYSRST_DEBOUNCE_COUNTER_VALUE_p - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          btn_db_q, btn_db_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    s1_d      = i_btn_rst_n;
    s2_d      = s1_q;
    btn_db_d  = btn_db_q;
    deb_cnt_d = '0;
    // Only an unbroken run of D mismatching cycles moves the debounced level.
    if (s2_q != btn_db_q) begin
      if (deb_cnt_q == D_LAST) begin
        btn_db_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      btn_db_q  <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      btn_db_q  <= btn_db_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign o_btn_db = btn_db_q;

endmodule

// File: rtl/ccr.sv
// rtl/ccr.sv - clock/reset controller top: clock pass-through, reset FSM, optional PLL lock wait
// CCR_PLL_LOCK_WAIT_EN enables the lock-wait state between button release and reset release.
module ccr
  import ccr_pkg::*;
#(
  parameter int unsigned SYSRST_DEBOUNCE_COUNTER_VALUE_p = SYSRST_DEBOUNCE_COUNTER_VALUE_DEF,
  parameter int unsigned PLL_LOCK_COUNTER_VALUE_p        = PLL_LOCK_COUNTER_VALUE_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_rst_n,
  output logic o_clk,
  output logic o_rst_n
);

  if (SYSRST_DEBOUNCE_COUNTER_VALUE_p < 2) begin : g_bad_debounce
    $error("SYSRST_DEBOUNCE_COUNTER_VALUE_p must be at least 2");
  end
  if (PLL_LOCK_COUNTER_VALUE_p < 2) begin : g_bad_lock
    $error("PLL_LOCK_COUNTER_VALUE_p must be at least 2");
  end

  assign o_clk = i_clk;

  logic btn_db;

  ccr_debounce #(
    .SYSRST_DEBOUNCE_COUNTER_VALUE_p(SYSRST_DEBOUNCE_COUNTER_VALUE_p)
  ) u_debounce (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_btn_rst_n (i_btn_rst_n),
    .o_btn_db    (btn_db)
  );

  ccr_state_t state_q, state_d;
  logic       rst_n_q, rst_n_d;

`ifdef CCR_PLL_LOCK_WAIT_EN
  localparam int unsigned LW = $clog2(PLL_LOCK_COUNTER_VALUE_p + 1);
  localparam logic [LW-1:0] L_LAST = LW'(PLL_LOCK_COUNTER_VALUE_p - 1);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    rst_n_d = rst_n_q;
`ifdef CCR_PLL_LOCK_WAIT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      RESET_ST: begin
        rst_n_d = 1'b0;
        if (btn_db) begin
`ifdef CCR_PLL_LOCK_WAIT_EN
          state_d    = WAIT_LOCK_ST;
          lock_cnt_d = '0;
`else
          state_d = RUN_ST;
          rst_n_d = 1'b1;
`endif
        end
      end
`ifdef CCR_PLL_LOCK_WAIT_EN
      WAIT_LOCK_ST: begin
        // Counter leaves this state at L-1, so it never reaches wrap.
        rst_n_d    = 1'b0;
        lock_cnt_d = lock_cnt_q + LW'(1);
        if (!btn_db) begin
          state_d = RESET_ST;
        end else if (lock_cnt_q == L_LAST) begin
          state_d = RUN_ST;
          rst_n_d = 1'b1;
        end
      end
`endif
      RUN_ST: begin
        rst_n_d = 1'b1;
        if (!btn_db) begin
          state_d = RESET_ST;
          rst_n_d = 1'b0;
        end
      end
      default: begin
        state_d = RESET_ST;
        rst_n_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RESET_ST;
      rst_n_q <= 1'b0;
`ifdef CCR_PLL_LOCK_WAIT_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rst_n_q <= rst_n_d;
`ifdef CCR_PLL_LOCK_WAIT_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign o_rst_n = rst_n_q;

endmodule

// File: tb/tb_ccr.sv
// tb/tb_ccr.sv - self-checking bench for ccr: o_rst_n edge scoreboard plus glitch vector table
module tb_ccr;

  localparam int D = 15;
  localparam int L = 20;
  localparam int PRESS_LAT = D + 3;
`ifdef CCR_PLL_LOCK_WAIT_EN
  localparam int REL_LAT = D + L + 3;
`else
  localparam int REL_LAT = D + 3;
`endif

  typedef struct {
    int cyc;
    bit val;
  } ev_t;

  typedef struct {
    int len;
    bit toggles;
  } glitch_t;

  logic clk = 1'b0;
  logic i_rst;
  logic i_btn_rst_n;
  logic o_clk;
  logic o_rst_n;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  ev_t  sb[$];
  ev_t  mon_ev;
  logic prev_rst_n = 1'b0;
  glitch_t vec[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ccr #(
    .SYSRST_DEBOUNCE_COUNTER_VALUE_p(D),
    .PLL_LOCK_COUNTER_VALUE_p(L)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_btn_rst_n (i_btn_rst_n),
    .o_clk       (o_clk),
    .o_rst_n     (o_rst_n)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input bit v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (o_rst_n !== prev_rst_n) begin
      prev_rst_n <= o_rst_n;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_edge: o_rst_n went %0d at cycle %0d, required no edge", o_rst_n, cyc);
      end else begin
        mon_ev = sb.pop_front();
        check("edge_cycle", cyc, mon_ev.cyc);
        check("edge_value", int'(o_rst_n), int'(mon_ev.val));
      end
    end
  end

  initial begin
    vec[0] = '{len: 3,  toggles: 1'b0};
    vec[1] = '{len: 10, toggles: 1'b0};
    vec[2] = '{len: 14, toggles: 1'b0};
    vec[3] = '{len: 15, toggles: 1'b1};
    vec[4] = '{len: 40, toggles: 1'b1};

    i_rst       = 1'b1;
    i_btn_rst_n = 1'b0;

    // block reset held with button pressed
    repeat (5) begin
      tick();
      check("reset_rst_n", int'(o_rst_n), 0);
      check("o_clk_high", int'(o_clk), 1);
    end
    #5;
    check("o_clk_low", int'(o_clk), 0);
    tick();
    i_rst = 1'b0;

    // first release, 10 cycles after reset drop
    repeat (10) tick();
    i_btn_rst_n = 1'b1;
    push(cyc + REL_LAT, 1'b1);
    settle(REL_LAT + 10);
    check("run_after_release", int'(o_rst_n), 1);

    // long press while running, then release
    i_btn_rst_n = 1'b0;
    push(cyc + PRESS_LAT, 1'b0);
    repeat (50) tick();
    i_btn_rst_n = 1'b1;
    push(cyc + REL_LAT, 1'b1);
    settle(REL_LAT + 10);
    check("run_after_press_release", int'(o_rst_n), 1);

    // low glitches of varying length while running
    for (int i = 0; i < 5; i++) begin
      i_btn_rst_n = 1'b0;
      if (vec[i].toggles) push(cyc + PRESS_LAT, 1'b0);
      repeat (vec[i].len) tick();
      i_btn_rst_n = 1'b1;
      if (vec[i].toggles) push(cyc + REL_LAT, 1'b1);
      settle(REL_LAT + 10);
      check($sformatf("glitch_%0d_final", vec[i].len), int'(o_rst_n), 1);
    end

    // bouncing release from a settled press
    i_btn_rst_n = 1'b0;
    push(cyc + PRESS_LAT, 1'b0);
    repeat (30) tick();
    check("pressed_before_bounce", int'(o_rst_n), 0);
    i_btn_rst_n = 1'b1; repeat (4) tick();
    i_btn_rst_n = 1'b0; repeat (3) tick();
    i_btn_rst_n = 1'b1; repeat (5) tick();
    i_btn_rst_n = 1'b0; repeat (2) tick();
    i_btn_rst_n = 1'b1;
    push(cyc + REL_LAT, 1'b1);
    settle(REL_LAT + 10);
    check("run_after_bounce", int'(o_rst_n), 1);

    // re-press while the lock wait is in progress
    i_btn_rst_n = 1'b0;
    push(cyc + PRESS_LAT, 1'b0);
    repeat (30) tick();
    i_btn_rst_n = 1'b1;
`ifndef CCR_PLL_LOCK_WAIT_EN
    push(cyc + REL_LAT, 1'b1);
`endif
    repeat (D + 3) tick();
    i_btn_rst_n = 1'b0;
`ifndef CCR_PLL_LOCK_WAIT_EN
    push(cyc + PRESS_LAT, 1'b0);
`endif
    repeat (30) tick();
    check("held_after_repress", int'(o_rst_n), 0);
    i_btn_rst_n = 1'b1;
    push(cyc + REL_LAT, 1'b1);
    settle(REL_LAT + 10);
    check("run_after_repress", int'(o_rst_n), 1);

    // block reset pulse while running
    i_rst = 1'b1;
    push(cyc + 1, 1'b0);
    tick();
    check("rst_next_edge", int'(o_rst_n), 0);
    i_rst = 1'b0;
    push(cyc + REL_LAT, 1'b1);
    settle(REL_LAT + 10);
    check("run_after_i_rst", int'(o_rst_n), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
